// File: rtl/des_key_schedule_if.sv
// Handshake and subkey stream bundle for des_key_schedule.
// key_err exists only when DES_KEY_PARITY_CHECK_EN is defined.
interface des_key_schedule_if #(
  parameter int IDX_W = 4
);
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic [63:0]      key;
  logic             decrypt;
  logic [47:0]      subkey;
  logic [IDX_W-1:0] subkey_idx;
  logic             subkey_valid;
  logic             subkey_ready;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic             key_err;

  modport master (
    output ap_start, key, decrypt, subkey_ready,
    input  ap_ready, ap_done, ap_idle, subkey, subkey_idx, subkey_valid, key_err
  );
  modport slave (
    input  ap_start, key, decrypt, subkey_ready,
    output ap_ready, ap_done, ap_idle, subkey, subkey_idx, subkey_valid, key_err
  );
`else
  modport master (
    output ap_start, key, decrypt, subkey_ready,
    input  ap_ready, ap_done, ap_idle, subkey, subkey_idx, subkey_valid
  );
  modport slave (
    input  ap_start, key, decrypt, subkey_ready,
    output ap_ready, ap_done, ap_idle, subkey, subkey_idx, subkey_valid
  );
`endif
endinterface

// File: rtl/des_key_schedule.sv
// DES key schedule: PC1, C/D rotation and PC2 streamed at PERM_BITS_PER_CYCLE bits per cycle.
// Optional key byte parity check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_schedule #(
  parameter int PERM_BITS_PER_CYCLE = 1,
  parameter int ROUNDS              = 16,
  parameter int IDX_W               = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  des_key_schedule_if.slave    bus
);

  localparam int P = PERM_BITS_PER_CYCLE;
  localparam logic [5:0] PC1_LAST = 6'(56 / P - 1);
  localparam logic [5:0] PC2_LAST = 6'(48 / P - 1);
  localparam logic [4:0] NROUNDS  = 5'(ROUNDS);

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic int unsigned shift_of(input logic [4:0] j);
    case (j)
      5'd1, 5'd2, 5'd9, 5'd16: return 1;
      default:                 return 2;
    endcase
  endfunction

  function automatic int unsigned total_shift();
    int unsigned s;
    s = 0;
    for (int unsigned j = 1; j <= ROUNDS; j++) s += shift_of(5'(j));
    return s % 28;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input int unsigned n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input int unsigned n);
    logic [55:0] t;
    t = {x, x} >> n;
    return t[27:0];
  endfunction

  localparam int unsigned TOTAL = total_shift();

  typedef enum logic [2:0] {S_IDLE, S_PC1, S_SHIFT, S_PC2, S_OUT, S_DONE} state_t;
  state_t state, state_n;

  logic [55:0]      pc1_perm;
  logic [55:0]      pend1;
  logic [47:0]      pend2;
  logic [47:0]      pc2_perm;
  logic [55:0]      cd_next;
  logic [55:0]      cd_rot;
  logic [27:0]      c, d, c_rot, d_rot;
  logic             dec_q;
  logic [5:0]       cnt;
  logic [4:0]       rnd, rnd_n;
  logic [47:0]      subkey_q;
  logic [IDX_W-1:0] idx_q;
  logic             key_bad;

  // Both permutations are wired in parallel; the bits are then shifted into C/D
  // and the subkey register P at a time to keep the serial cycle timing.
  for (genvar k = 0; k < 56; k++) begin : g_pc1
    assign pc1_perm[55-k] = bus.key[64-PC1[k]];
  end
  assign cd_rot = {c_rot, d_rot};
  for (genvar k = 0; k < 48; k++) begin : g_pc2
    assign pc2_perm[47-k] = cd_rot[56-PC2[k]];
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic [7:0] byte_odd;
  logic       key_err_q;
  for (genvar b = 0; b < 8; b++) begin : g_par
    assign byte_odd[b] = ^bus.key[8*b +: 8];
  end
  assign key_bad     = ~&byte_odd;
  assign bus.key_err = key_err_q;
`else
  assign key_bad = 1'b0;
`endif

  assign cd_next = 56'({c, d, pend1[55 -: P]});
  assign rnd_n   = rnd + 5'd1;

  // Decrypt starts from C_ROUNDS/D_ROUNDS and walks the rotations backwards.
  always_comb begin
    c_rot = c;
    d_rot = d;
    if (!dec_q) begin
      c_rot = rotl(c, shift_of(rnd_n));
      d_rot = rotl(d, shift_of(rnd_n));
    end else if (rnd_n != 5'd1) begin
      c_rot = rotr(c, shift_of(NROUNDS - rnd_n + 5'd2));
      d_rot = rotr(d, shift_of(NROUNDS - rnd_n + 5'd2));
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n          = state;
    bus.ap_ready     = 1'b0;
    bus.ap_done      = 1'b0;
    bus.ap_idle      = 1'b0;
    bus.subkey_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.ap_idle = ~bus.ap_start;
        if (bus.ap_start) begin
          bus.ap_ready = 1'b1;
          state_n      = key_bad ? S_DONE : S_PC1;
        end
      end
      S_PC1:   if (cnt == PC1_LAST) state_n = S_SHIFT;
      S_SHIFT: state_n = S_PC2;
      S_PC2:   if (cnt == PC2_LAST) state_n = S_OUT;
      S_OUT: begin
        bus.subkey_valid = 1'b1;
        if (bus.subkey_ready) state_n = (rnd == NROUNDS) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        bus.ap_done = 1'b1;
        state_n     = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      pend1    <= '0;
      pend2    <= '0;
      c        <= '0;
      d        <= '0;
      dec_q    <= 1'b0;
      cnt      <= '0;
      rnd      <= '0;
      subkey_q <= '0;
      idx_q    <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
      key_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (bus.ap_start) begin
            pend1 <= pc1_perm;
            dec_q <= bus.decrypt;
            rnd   <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
            key_err_q <= key_bad;
`endif
          end
        end
        S_PC1: begin
          pend1 <= pend1 << P;
          if (cnt == PC1_LAST) begin
            cnt <= '0;
            c   <= dec_q ? rotl(cd_next[55:28], TOTAL) : cd_next[55:28];
            d   <= dec_q ? rotl(cd_next[27:0], TOTAL)  : cd_next[27:0];
          end else begin
            cnt    <= cnt + 6'd1;
            {c, d} <= cd_next;
          end
        end
        S_SHIFT: begin
          c     <= c_rot;
          d     <= d_rot;
          pend2 <= pc2_perm;
          rnd   <= rnd_n;
          idx_q <= dec_q ? IDX_W'(NROUNDS - rnd_n + 5'd1) : IDX_W'(rnd_n);
          cnt   <= '0;
        end
        S_PC2: begin
          pend2    <= pend2 << P;
          subkey_q <= 48'({subkey_q, pend2[47 -: P]});
          cnt      <= (cnt == PC2_LAST) ? 6'd0 : cnt + 6'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.subkey     = subkey_q;
  assign bus.subkey_idx = idx_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: P=1 and P=8 instances against the classic 133457799BBCDFF1 schedule.
module tb_des_key_schedule;

  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
  localparam logic [63:0] BADKEY = 64'h123457799BBCDFF1;
  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc;

  always #5 clk = ~clk;

  // subkey_idx reaches 16, so the bench widens it to 5 bits
  des_key_schedule_if #(.IDX_W(5)) bus  ();
  des_key_schedule_if #(.IDX_W(5)) bus8 ();

  des_key_schedule #(.PERM_BITS_PER_CYCLE(1), .ROUNDS(16), .IDX_W(5)) u_dut (
    .ap_clk(clk), .ap_rst(rst), .bus(bus)
  );
  des_key_schedule #(.PERM_BITS_PER_CYCLE(8), .ROUNDS(16), .IDX_W(5)) u_dut8 (
    .ap_clk(clk), .ap_rst(rst), .bus(bus8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start(input bit sel, input logic [63:0] k, input logic dec);
    if (sel) begin
      bus8.key = k; bus8.decrypt = dec; bus8.ap_start = 1'b1;
    end else begin
      bus.key = k; bus.decrypt = dec; bus.ap_start = 1'b1;
    end
    #1;
    chk("start_ready", sel ? bus8.ap_ready : bus.ap_ready, 1);
    chk("start_idle_low", sel ? bus8.ap_idle : bus.ap_idle, 0);
    @(posedge clk); #1;
    bus.ap_start  = 1'b0;
    bus8.ap_start = 1'b0;
  endtask

  // Returns the cycle index (first call point = 1) at which subkey_valid is seen.
  task automatic wait_valid(input bit sel, input int budget, output int c);
    c = 1;
    while (!(sel ? bus8.subkey_valid : bus.subkey_valid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("valid_seen", sel ? bus8.subkey_valid : bus.subkey_valid, 1);
  endtask

  task automatic accept();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.ap_start = 1'b0;  bus.key = '0;  bus.decrypt = 1'b0;  bus.subkey_ready = 1'b1;
    bus8.ap_start = 1'b0; bus8.key = '0; bus8.decrypt = 1'b0; bus8.subkey_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", bus.ap_idle, 1);
    chk("rst_done", bus.ap_done, 0);
    chk("rst_ready", bus.ap_ready, 0);
    chk("rst_valid", bus.subkey_valid, 0);
    chk("rst_subkey", bus.subkey, 0);
    chk("rst_idx", bus.subkey_idx, 0);
    chk("rst_valid8", bus8.subkey_valid, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Encrypt, with backpressure on round 3 and ignored starts while busy
    start(0, KEY, 0);
`ifdef DES_KEY_PARITY_CHECK_EN
    chk("good_key_err", bus.key_err, 0);
`endif
    for (int r = 1; r <= 16; r++) begin
      wait_valid(0, 300, cyc);
      if (r == 1) chk("enc_first_cycle", cyc, 106);
      if (r == 2) chk("enc_round_period", cyc, 50);
      chk($sformatf("enc_k%0d", r), bus.subkey, KS[r-1]);
      chk($sformatf("enc_idx%0d", r), bus.subkey_idx, r);
      if (r == 3) begin
        for (int k = 0; k < 20; k++) begin
          if (k == 5) begin bus.key = BADKEY; bus.decrypt = 1'b1; bus.ap_start = 1'b1; end
          if (k == 7) bus.ap_start = 1'b0;
          @(posedge clk); #1;
          chk("bp_valid", bus.subkey_valid, 1);
          chk("bp_subkey", bus.subkey, KS[2]);
          chk("bp_idx", bus.subkey_idx, 3);
          if (k == 5) chk("busy_start_no_ready", bus.ap_ready, 0);
        end
        bus.subkey_ready = 1'b1; bus.key = KEY; bus.decrypt = 1'b0;
      end
      accept();
      if (r == 2) bus.subkey_ready = 1'b0;
    end
    chk("enc_done", bus.ap_done, 1);
    chk("enc_done_valid", bus.subkey_valid, 0);
    @(posedge clk); #1;
    chk("enc_done_pulse", bus.ap_done, 0);
    chk("enc_back_idle", bus.ap_idle, 1);

    // Decrypt
    start(0, KEY, 1);
    for (int r = 1; r <= 16; r++) begin
      wait_valid(0, 300, cyc);
      if (r == 1) chk("dec_first_cycle", cyc, 106);
      chk($sformatf("dec_k%0d", r), bus.subkey, KS[16-r]);
      chk($sformatf("dec_idx%0d", r), bus.subkey_idx, 17 - r);
      accept();
    end
    chk("dec_done", bus.ap_done, 1);
    @(posedge clk); #1;

    // Reset during PC2 of round 5, then a clean restart
    start(0, KEY, 0);
    for (int r = 1; r <= 4; r++) begin
      wait_valid(0, 300, cyc);
      chk($sformatf("mid_k%0d", r), bus.subkey, KS[r-1]);
      accept();
    end
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.subkey_valid, 0);
    chk("mid_rst_idle", bus.ap_idle, 1);
    chk("mid_rst_idx", bus.subkey_idx, 0);
    chk("mid_rst_subkey", bus.subkey, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start(0, KEY, 0);
    wait_valid(0, 300, cyc);
    chk("restart_cycle", cyc, 106);
    chk("restart_k1", bus.subkey, KS[0]);
    chk("restart_idx1", bus.subkey_idx, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef DES_KEY_PARITY_CHECK_EN
    start(0, BADKEY, 0);
    chk("par_done", bus.ap_done, 1);
    chk("par_err", bus.key_err, 1);
    chk("par_valid", bus.subkey_valid, 0);
    @(posedge clk); #1;
    chk("par_idle", bus.ap_idle, 1);
    chk("par_err_hold", bus.key_err, 1);
    chk("par_valid2", bus.subkey_valid, 0);
`endif

    // P=8 instance on the good key
    start(1, KEY, 0);
    for (int r = 1; r <= 16; r++) begin
      wait_valid(1, 100, cyc);
      if (r == 1) chk("p8_first_cycle", cyc, 15);
      if (r == 2) chk("p8_round_period", cyc, 8);
      chk($sformatf("p8_k%0d", r), bus8.subkey, KS[r-1]);
      chk($sformatf("p8_idx%0d", r), bus8.subkey_idx, r);
      accept();
    end
    chk("p8_done", bus8.ap_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
